// File: rtl/pipeline_stage.sv
// Pipeline register stage with a two-entry skid buffer.
// The main entry drives the outputs. The skid entry catches one word when the
// main entry is stalled. This lets in_ready come from registered state only.
module pipeline_stage #(
    parameter int DATA_W   = 64,
    parameter int NUM_DATA = 4,
    parameter int CTRL_W   = 9,
    parameter int REG_W    = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_DATA*DATA_W-1:0]   data_in,
    input  logic [CTRL_W-1:0]            ctrl_in,
    input  logic [REG_W-1:0]             wreg_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_DATA*DATA_W-1:0]   data_out,
    output logic [CTRL_W-1:0]            ctrl_out,
    output logic [REG_W-1:0]             wreg_out,
    output logic [1:0]                   occupancy
);

    localparam int DW = NUM_DATA * DATA_W;

    logic [DW-1:0]     main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [REG_W-1:0]  main_wreg, skid_wreg;
    logic              main_valid, skid_valid;
    logic              accept, drain;

    // Handshake qualifiers; in_ready depends only on the skid flag and reset.
    always_comb begin
        in_ready = ~skid_valid & ~reset;
        accept   = in_valid & in_ready;
        drain    = main_valid & out_ready;
    end

    // Main and skid entry update.
    // An entry's ctrl is zeroed whenever the entry is invalidated. A bubble
    // therefore never carries stale control bits, and no output gating is needed.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_data  <= '0;
            main_ctrl  <= '0;
            main_wreg  <= '0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            skid_wreg  <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else if (~main_valid | drain) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                main_wreg  <= skid_wreg;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
            end else if (accept) begin
                main_data  <= data_in;
                main_ctrl  <= ctrl_in;
                main_wreg  <= wreg_in;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
        end else if (accept) begin
            skid_data  <= data_in;
            skid_ctrl  <= ctrl_in;
            skid_wreg  <= wreg_in;
            skid_valid <= 1'b1;
        end
    end

    // Registered outputs and fill level.
    always_comb begin
        out_valid = main_valid;
        data_out  = main_data;
        ctrl_out  = main_ctrl;
        wreg_out  = main_wreg;
        occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    end

endmodule

// File: doc/pipeline_stage.md
PIPELINE_STAGE -- requirements
Module: pipeline_stage

Interface
REQ-001 Parameter DATA_W, default 64, width of one datapath word.
REQ-002 Parameter NUM_DATA, default 4, number of datapath words carried (pc, alu result, read data 1/2).
REQ-003 Parameter CTRL_W, default 9, number of control bits (Branch, MemRead, MemtoReg, MemWrite, Uncondbranch, Branchreg, not_zero, zero, RegWrite).
REQ-004 Parameter REG_W, default 5, destination-register index width.
REQ-005 clock  input  1  sole clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-007 flush  input  1  discard all held and incoming contents, insert bubble.
REQ-008 in_valid  input  1  upstream stage presents a valid instruction.
REQ-009 in_ready  output  1  stage can accept this cycle.
REQ-010 data_in  input  NUM_DATA*DATA_W  packed datapath words, word 0 in LSBs.
REQ-011 ctrl_in  input  CTRL_W  control bits.
REQ-012 wreg_in  input  REG_W  destination register index.
REQ-013 out_valid  output  1  output holds a valid instruction.
REQ-014 out_ready  input  1  downstream accepts; low = stall.
REQ-015 data_out / ctrl_out / wreg_out  output  same widths as inputs  registered stage contents.
REQ-016 occupancy  output  2  entries held (0..2).

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; each holds data, ctrl, wreg, valid.
REQ-018 accept = in_valid & in_ready; drain = out_valid & out_ready; both evaluated per cycle.
REQ-019 in_ready SHALL equal ~skid_valid & ~reset, driven from registered state only; no combinational path from out_ready.
REQ-020 Latency SHALL be 1 cycle: accepted input appears on outputs next cycle if main empty or draining and skid empty.
REQ-021 Throughput SHALL be one transfer per cycle with out_ready held high.
REQ-022 When main is empty or draining: main loads skid if skid_valid (skid cleared), else loads input if accept, else becomes invalid.
REQ-023 When main is valid, not draining, and accept: input SHALL be written to skid, skid_valid set.
REQ-024 While out_valid & ~out_ready, data_out, ctrl_out, wreg_out SHALL remain stable.
REQ-025 Whenever out_valid = 0, ctrl_out SHALL be all zero (bubble: no RegWrite, MemWrite, Branch); data_out/wreg_out hold last value.
REQ-026 flush SHALL, at next edge, clear main and skid valid bits and zero both ctrl fields; input accepted in the flush cycle is discarded.
REQ-027 flush SHALL take priority over accept and drain in the same cycle; a drain in a flush cycle still counts as delivered downstream.
REQ-028 occupancy SHALL equal main_valid + skid_valid.
REQ-029 No data SHALL be lost or duplicated: transfers out occur in acceptance order, each exactly once, absent flush.
REQ-030 NUM_DATA = 1 and CTRL_W = 1 SHALL be legal configurations.

Reset
REQ-031 With reset high at an edge, all data, ctrl, wreg, and valid bits in both entries SHALL become zero.
REQ-032 During reset, in_ready SHALL be 0 and inputs ignored; after deassertion in_ready = 1, out_valid = 0, occupancy = 0.
REQ-033 reset SHALL override flush and all handshakes; reset mid-stall discards both entries.

Verification
REQ-034 Stream: in_valid=1, out_ready=1, data_in word0 = 1,2,3... each cycle -> out_valid from cycle 1, data_out word0 = 1,2,3 one cycle later, occupancy = 1.
REQ-035 Stall: accept A=0xA, B=0xB with out_ready=0 -> occupancy 2, in_ready=0, outputs hold A; raise out_ready -> A then B delivered, in_ready returns 1 after skid drains.
REQ-036 Flush with occupancy 2 and ctrl_in=9'h1FF -> next cycle out_valid=0, ctrl_out=0, occupancy=0, in_ready=1.
REQ-037 Flush concurrent with in_valid=1 -> that input never appears on outputs.
REQ-038 Reset asserted while occupancy 2 -> all outputs zero next cycle, in_ready=0 during reset, 1 after.
REQ-039 Random in_valid/out_ready over 10k cycles with scoreboard -> in-order, lossless, no duplicates, ctrl_out zero whenever out_valid=0.
